// File: rtl/seven_seg_scan_reader.sv
// Rebuilds four BCD digits from a scanned 7-segment display; flags undecodable glyphs and a stalled scan.
// Latency: 1 input register + SETTLE_CYCLES per digit sample; frame published 1 cycle after the 4th sample. No backpressure.
module seven_seg_scan_reader #(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter bit ANODE_ACT_LOW  = 1'b1,
    parameter bit SEG_ACT_LOW    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        segA,
    input  logic        segB,
    input  logic        segC,
    input  logic        segD,
    input  logic        segE,
    input  logic        segF,
    input  logic        segG,
    input  logic [3:0]  anode,
    output logic [15:0] bcd,
    output logic        bcd_valid,
    output logic        frame_stb,
    output logic        code_err,
    output logic        scan_timeout
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [7:0]    SETTLE_LAST  = 8'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {WAIT, SETTLE, HOLD} state_t;

    logic [6:0]    seg_raw;
    logic [6:0]    seg_q;
    logic [3:0]    an_q;
    logic          an_vld;
    logic [1:0]    an_idx;
    logic [4:0]    dec;
    logic          same_idx;
    logic          sample;

    state_t        state;
    logic [7:0]    cnt;
    logic [1:0]    idx;
    logic [15:0]   shadow;
    logic [3:0]    seen;
    logic          err_acc;
    logic [TW-1:0] tcnt;

    assign seg_raw = {segA, segB, segC, segD, segE, segF, segG};

    // Both input buses are normalised to active-high as they are registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q <= 7'd0;
            an_q  <= 4'd0;
        end else begin
            seg_q <= SEG_ACT_LOW   ? ~seg_raw : seg_raw;
            an_q  <= ANODE_ACT_LOW ? ~anode   : anode;
        end
    end

    always_comb begin
        an_vld = 1'b0;
        an_idx = 2'd0;
        case (an_q)
            4'b0001: begin an_vld = 1'b1; an_idx = 2'd0; end
            4'b0010: begin an_vld = 1'b1; an_idx = 2'd1; end
            4'b0100: begin an_vld = 1'b1; an_idx = 2'd2; end
            4'b1000: begin an_vld = 1'b1; an_idx = 2'd3; end
            default: begin an_vld = 1'b0; an_idx = 2'd0; end
        endcase
    end

    // Returns {err, value}; unknown glyphs read as 4'hF with err set.
    function automatic logic [4:0] seg_decode(input logic [6:0] s);
        case (s)
            7'b1111110: return 5'h00;
            7'b0110000: return 5'h01;
            7'b1101101: return 5'h02;
            7'b1111001: return 5'h03;
            7'b0110011: return 5'h04;
            7'b1011011: return 5'h05;
            7'b1011111: return 5'h06;
            7'b1110000: return 5'h07;
            7'b1111111: return 5'h08;
            7'b1111011: return 5'h09;
            default:    return 5'h1F;
        endcase
    endfunction

    assign dec      = seg_decode(seg_q);
    assign same_idx = an_vld && (an_idx == idx);
    assign sample   = (state == SETTLE) && same_idx && (cnt == SETTLE_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= WAIT;
            cnt          <= 8'd0;
            idx          <= 2'd0;
            shadow       <= 16'h0;
            seen         <= 4'b0000;
            err_acc      <= 1'b0;
            tcnt         <= '0;
            bcd          <= 16'h0;
            bcd_valid    <= 1'b0;
            frame_stb    <= 1'b0;
            code_err     <= 1'b0;
            scan_timeout <= 1'b0;
        end else begin
            frame_stb <= 1'b0;
            code_err  <= 1'b0;

            case (state)
                WAIT: begin
                    if (an_vld) begin
                        cnt   <= 8'd0;
                        idx   <= an_idx;
                        state <= SETTLE;
                    end
                end
                SETTLE, HOLD: begin
                    if (!same_idx) begin
                        cnt   <= 8'd0;
                        idx   <= an_idx;
                        state <= an_vld ? SETTLE : WAIT;
                    end else if (state == SETTLE) begin
                        cnt <= cnt + 8'd1;
                        if (cnt == SETTLE_LAST) state <= HOLD;
                    end
                end
                default: state <= WAIT;
            endcase

            // Publish reads the registered shadow, so a coincident sample lands in the next frame.
            if (seen == 4'b1111) begin
                bcd       <= shadow;
                frame_stb <= 1'b1;
                code_err  <= err_acc;
                bcd_valid <= 1'b1;
                seen      <= 4'b0000;
                err_acc   <= 1'b0;
            end

            if (sample) begin
                shadow[{idx, 2'b00} +: 4] <= dec[3:0];
                seen[idx]                 <= 1'b1;
                if (dec[4]) err_acc <= 1'b1;
                tcnt         <= '0;
                scan_timeout <= 1'b0;
            end else if (tcnt == TIMEOUT_LAST) begin
                scan_timeout <= 1'b1;
                bcd_valid    <= 1'b0;
                seen         <= 4'b0000;
                err_acc      <= 1'b0;
            end else begin
                tcnt <= tcnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_reader.sv
// Bench for seven_seg_scan_reader: randomized scans against a frame-level digit model.
module tb_seven_seg_scan_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        segA, segB, segC, segD, segE, segF, segG;
    logic [3:0]  anode = 4'hF;
    logic [15:0] bcd;
    logic        bcd_valid, frame_stb, code_err, scan_timeout;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int stb_cyc = 0;
    int stray = 0;

    logic [15:0] q_bcd[$];
    logic        q_err[$];
    logic        q_vld[$];

    logic [6:0]  pat[4];
    int          ord[4];

    seven_seg_scan_reader #(
        .SETTLE_CYCLES(4), .TIMEOUT_CYCLES(64), .ANODE_ACT_LOW(1'b1), .SEG_ACT_LOW(1'b1)
    ) dut (
        .clk(clk), .rst(rst),
        .segA(segA), .segB(segB), .segC(segC), .segD(segD), .segE(segE), .segF(segF), .segG(segG),
        .anode(anode), .bcd(bcd), .bcd_valid(bcd_valid), .frame_stb(frame_stb),
        .code_err(code_err), .scan_timeout(scan_timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frame_stb) begin
            q_bcd.push_back(bcd);
            q_err.push_back(code_err);
            q_vld.push_back(bcd_valid);
            stb_cyc = cyc;
        end
        if (code_err && !frame_stb) stray++;
    end

    // Glyph table {a..g} active-high.
    function automatic logic [6:0] enc(input int d);
        case (d)
            0: return 7'b1111110;  1: return 7'b0110000;  2: return 7'b1101101;
            3: return 7'b1111001;  4: return 7'b0110011;  5: return 7'b1011011;
            6: return 7'b1011111;  7: return 7'b1110000;  8: return 7'b1111111;
            default: return 7'b1111011;
        endcase
    endfunction

    function automatic logic [3:0] glyph_value(input logic [6:0] p);
        for (int d = 0; d < 10; d++) if (enc(d) == p) return 4'(d);
        return 4'hF;
    endfunction

    function automatic logic [15:0] model_bcd();
        logic [15:0] e = 16'h0;
        for (int i = 0; i < 4; i++) e[i*4 +: 4] = glyph_value(pat[i]);
        return e;
    endfunction

    function automatic logic model_err();
        for (int i = 0; i < 4; i++) if (glyph_value(pat[i]) == 4'hF) return 1'b1;
        return 1'b0;
    endfunction

    // Drive one digit (active-low lines) and hold it for n clock edges.
    task automatic show(input int d, input logic [6:0] p, input int n);
        anode = ~(4'b0001 << d);
        {segA, segB, segC, segD, segE, segF, segG} = ~p;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic blank(input int n);
        anode = 4'hF;
        {segA, segB, segC, segD, segE, segF, segG} = 7'h7F;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic random_digits();
        for (int i = 0; i < 4; i++) begin
            pat[i] = enc($urandom_range(0, 9));
            ord[i] = i;
        end
        for (int i = 3; i > 0; i--) begin
            int j = $urandom_range(0, i);
            int t = ord[i];
            ord[i] = ord[j];
            ord[j] = t;
        end
    endtask

    task automatic scan_all(input int dwell);
        for (int i = 0; i < 4; i++) show(ord[i], pat[ord[i]], dwell);
        blank(4);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        blank(3);
        n_cmp++; if (bcd !== 16'h0) begin n_bad++; $display("FAIL reset_bcd got %h want 0000", bcd); end
        n_cmp++; if (bcd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", bcd_valid); end
        n_cmp++; if (frame_stb !== 1'b0) begin n_bad++; $display("FAIL reset_stb got %b want 0", frame_stb); end
        n_cmp++; if (code_err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", code_err); end
        n_cmp++; if (scan_timeout !== 1'b0) begin n_bad++; $display("FAIL reset_tmo got %b want 0", scan_timeout); end
        rst = 1'b0;
        blank(2);
    endtask

    task automatic test_frames();
        for (int it = 0; it < 6; it++) begin
            random_digits();
            if (it == 0) begin
                pat[0] = enc(4); pat[1] = enc(3); pat[2] = enc(2); pat[3] = enc(1);
                for (int i = 0; i < 4; i++) ord[i] = i;
            end
            q_bcd.delete(); q_err.delete(); q_vld.delete();
            scan_all(8);
            n_cmp++;
            if (q_bcd.size() != 1) begin
                n_bad++; $display("FAIL frame_count it=%0d got %0d want 1", it, q_bcd.size());
            end else begin
                n_cmp++; if (q_bcd[0] !== model_bcd()) begin n_bad++; $display("FAIL frame_bcd it=%0d got %h want %h", it, q_bcd[0], model_bcd()); end
                n_cmp++; if (q_err[0] !== 1'b0) begin n_bad++; $display("FAIL frame_err it=%0d got %b want 0", it, q_err[0]); end
                n_cmp++; if (q_vld[0] !== 1'b1) begin n_bad++; $display("FAIL frame_valid it=%0d got %b want 1", it, q_vld[0]); end
            end
        end
    endtask

    task automatic test_code_err();
        for (int it = 0; it < 4; it++) begin
            int bad;
            random_digits();
            bad = (it == 0) ? 2 : $urandom_range(0, 3);
            if (it == 0) begin
                pat[0] = enc(4); pat[1] = enc(3); pat[3] = enc(1);
                pat[2] = 7'b1000000;
            end else begin
                do pat[bad] = 7'($urandom_range(0, 127)); while (glyph_value(pat[bad]) != 4'hF);
            end
            q_bcd.delete(); q_err.delete(); q_vld.delete();
            scan_all(8);
            n_cmp++;
            if (q_bcd.size() != 1) begin
                n_bad++; $display("FAIL err_count it=%0d got %0d want 1", it, q_bcd.size());
            end else begin
                n_cmp++; if (q_bcd[0] !== model_bcd()) begin n_bad++; $display("FAIL err_bcd it=%0d got %h want %h", it, q_bcd[0], model_bcd()); end
                n_cmp++; if (q_err[0] !== model_err()) begin n_bad++; $display("FAIL err_flag it=%0d got %b want %b", it, q_err[0], model_err()); end
            end
        end
        // A clean frame right after must not inherit the error.
        random_digits();
        q_bcd.delete(); q_err.delete(); q_vld.delete();
        scan_all(8);
        n_cmp++; if (q_err.size() != 1 || q_err[0] !== 1'b0) begin n_bad++; $display("FAIL err_cleared frames=%0d want one clean frame", q_err.size()); end
    endtask

    task automatic test_short_dwell();
        random_digits();
        for (int i = 0; i < 4; i++) ord[i] = i;
        q_bcd.delete(); q_err.delete(); q_vld.delete();
        show(0, pat[0], 8); show(1, pat[1], 8); show(2, pat[2], 8); show(3, pat[3], 2);
        blank(10);
        n_cmp++; if (q_bcd.size() != 0) begin n_bad++; $display("FAIL short_dwell frames got %0d want 0", q_bcd.size()); end
        show(3, pat[3], 8);
        blank(4);
        n_cmp++;
        if (q_bcd.size() != 1) begin n_bad++; $display("FAIL short_revisit frames got %0d want 1", q_bcd.size()); end
        else if (q_bcd[0] !== model_bcd()) begin n_bad++; $display("FAIL short_revisit bcd got %h want %h", q_bcd[0], model_bcd()); end
    endtask

    task automatic test_two_active();
        random_digits();
        q_bcd.delete(); q_err.delete(); q_vld.delete();
        show(0, pat[0], 8); show(1, pat[1], 8); show(2, pat[2], 8);
        anode = 4'b1100;
        {segA, segB, segC, segD, segE, segF, segG} = ~enc(8);
        repeat (20) @(posedge clk);
        #1;
        n_cmp++; if (q_bcd.size() != 0) begin n_bad++; $display("FAIL two_active frames got %0d want 0", q_bcd.size()); end
        show(3, pat[3], 8);
        blank(4);
        n_cmp++;
        if (q_bcd.size() != 1) begin n_bad++; $display("FAIL two_active_resume frames got %0d want 1", q_bcd.size()); end
        else if (q_bcd[0] !== model_bcd()) begin n_bad++; $display("FAIL two_active_resume bcd got %h want %h", q_bcd[0], model_bcd()); end
    endtask

    task automatic test_timeout();
        int tcyc = -1;
        pat[0] = enc(5); pat[1] = enc(0); pat[2] = enc(9); pat[3] = enc(0);
        for (int i = 0; i < 4; i++) ord[i] = i;
        q_bcd.delete(); q_err.delete(); q_vld.delete();
        for (int i = 0; i < 4; i++) show(i, pat[i], 8);
        anode = 4'hF;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (scan_timeout) begin tcyc = cyc; break; end
        end
        n_cmp++; if (q_bcd.size() != 1 || q_bcd[0] !== 16'h0905) begin n_bad++; $display("FAIL tmo_frame frames=%0d want one frame 0905", q_bcd.size()); end
        n_cmp++; if (tcyc < 0) begin n_bad++; $display("FAIL tmo_never got no timeout want timeout"); end
        // Last sample is one cycle before frame_stb; timeout lands 64 cycles after the sample.
        n_cmp++; if (tcyc - stb_cyc != 63) begin n_bad++; $display("FAIL tmo_delay got %0d want 63 cycles after frame_stb", tcyc - stb_cyc); end
        n_cmp++; if (bcd_valid !== 1'b0) begin n_bad++; $display("FAIL tmo_valid got %b want 0", bcd_valid); end
        n_cmp++; if (bcd !== 16'h0905) begin n_bad++; $display("FAIL tmo_bcd got %h want 0905", bcd); end
        @(posedge clk); #1;
        show(1, enc(7), 8);
        n_cmp++; if (scan_timeout !== 1'b0) begin n_bad++; $display("FAIL tmo_clear got %b want 0", scan_timeout); end
        blank(4);
    endtask

    task automatic test_reset_midframe();
        random_digits();
        scan_all(8);
        show(0, enc(1), 8); show(1, enc(2), 8); show(2, enc(3), 8);
        q_bcd.delete(); q_err.delete(); q_vld.delete();
        rst = 1'b1;
        #1;
        n_cmp++; if (bcd !== 16'h0 || bcd_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_out got bcd=%h vld=%b want 0000/0", bcd, bcd_valid); end
        @(posedge clk); #1;
        rst = 1'b0;
        show(3, enc(5), 8);
        blank(6);
        n_cmp++; if (q_bcd.size() != 0) begin n_bad++; $display("FAIL midrst_partial frames got %0d want 0", q_bcd.size()); end
        pat[0] = enc(8); pat[1] = enc(7); pat[2] = enc(6); pat[3] = enc(5);
        for (int i = 0; i < 4; i++) ord[i] = i;
        scan_all(8);
        n_cmp++;
        if (q_bcd.size() != 1) begin n_bad++; $display("FAIL midrst_frames got %0d want 1", q_bcd.size()); end
        else if (q_bcd[0] !== 16'h5678 || q_err[0] !== 1'b0) begin n_bad++; $display("FAIL midrst_bcd got %h err=%b want 5678 err=0", q_bcd[0], q_err[0]); end
    endtask

    task automatic test_stray_err();
        n_cmp++; if (stray != 0) begin n_bad++; $display("FAIL stray_code_err got %0d pulses want 0", stray); end
    endtask

    initial begin
        {segA, segB, segC, segD, segE, segF, segG} = 7'h7F;
        test_reset();
        test_frames();
        test_code_err();
        test_short_dwell();
        test_two_active();
        test_timeout();
        test_reset_midframe();
        test_stray_err();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
